ddr_nch_frame_arbiter: RTL and testbench
========================================

Name: ddr_nch_frame_arbiter

Overview:
- Generalised N-channel successor to the fixed two-camera/one-display DDR FIFO controller.
- Arbitrates burst write commands (camera write FIFOs -> DDR) and burst read commands (DDR -> display read FIFOs) for CH_NUM channels through one DDR command port.
- Manages per-channel multi-bank frame buffers with vsync-driven bank rotation, so the display never reads a bank being written (no tearing).
- Sits between the per-channel FIFOs and the DDR user-interface command/burst engine.

Parameters:
- CH_NUM, 4, number of video channels (1..8)
- ADDR_W, 28, command address width in 64-bit word units
- LEN_W, 10, width of burst length and FIFO level fields
- BURST_LEN, 64, maximum words per burst (≤ 2^LEN_W-1)
- FRAME_WORDS, 76800, 64-bit words per frame (640x480x16bpp)
- BANK_NUM, 3, frame buffers per channel (3..4)
- BANK_STRIDE, 1<<20, word offset between banks
- CH_STRIDE, 1<<22, word offset between channel regions

Ports:
- clk  in  1  system/DDR-user clock
- rst_n  in  1  asynchronous active-low reset
- ch_en  in  CH_NUM  channel enable
- ch_wr_level  in  CH_NUM*LEN_W  words held in each write FIFO
- ch_rd_space  in  CH_NUM*LEN_W  free words in each read FIFO
- ch_vin_vs  in  CH_NUM  input vsync per channel, already synchronised to clk
- vout_vs  in  1  display vsync, synchronised to clk
- cmd_valid  out  1  command request
- cmd_ready  in  1  command accepted
- cmd_wr  out  1  1=write burst, 0=read burst
- cmd_ch  out  $clog2(CH_NUM) (min 1)  channel of command
- cmd_addr  out  ADDR_W  word address
- cmd_len  out  LEN_W  burst length in words
- burst_done  in  1  single-cycle pulse: issued burst finished

Behaviour:
- Reset values:
  - cmd_valid/cmd_wr/cmd_ch/cmd_addr/cmd_len = 0.
  - Per channel: wr_bank=0, done_bank=BANK_NUM-1, rd_bank=BANK_NUM-1, wr_off=0, rd_off=0.
  - RR pointer = 0; pending-vsync flags clear.
- Rising-edge detectors on ch_vin_vs[i] and vout_vs set sticky pending flags.
- Slot order: wr0, rd0, wr1, rd1, ... (2*CH_NUM slots).
- len = min(BURST_LEN, FRAME_WORDS - off).
- Write slot i eligible: ch_en[i] & wr_off<FRAME_WORDS & ch_wr_level[i] >= len.
- Read slot i eligible: ch_en[i] & rd_off<FRAME_WORDS & ch_rd_space[i] >= len.
- FSM:
  - IDLE: apply pending vsyncs (below). If any slot is eligible -> ARB, else stay.
  - ARB (1 cycle): grant the first eligible slot at or after the RR pointer, wrapping. Register cmd_wr, cmd_ch, cmd_len, and cmd_addr = ch*CH_STRIDE + bank*BANK_STRIDE + off (bank = wr_bank or rd_bank). RR pointer = granted+1 mod 2*CH_NUM -> CMD.
  - CMD: cmd_valid=1, all fields stable until cmd_ready. On the handshake, the granted offset += cmd_len; cmd_valid drops next cycle -> WAIT.
  - WAIT: on burst_done -> IDLE. At most one command outstanding.
  - burst_done outside WAIT is ignored.
- Vsync application (IDLE only; edges arriving in ARB/CMD/WAIT are deferred, never lost):
  - Reader first: for every channel, rd_bank = done_bank, rd_off = 0.
  - Then writer, per channel with a pending vin edge:
    - If wr_off == FRAME_WORDS: done_bank = wr_bank; wr_bank = next bank after wr_bank mod BANK_NUM, skipping the (new) rd_bank.
    - Otherwise (incomplete frame): frame dropped; bank and done_bank unchanged.
    - wr_off = 0 in both cases.
  - Reader and writer edges for the same channel in the same application: the reader takes the old done_bank.
- A disabled channel keeps its offsets and banks; its vsyncs are still processed.
- Offsets never exceed FRAME_WORDS; no address wraps beyond the channel region.
- Reset mid-burst: all state returns to reset values immediately; the downstream engine is reset by the same rst_n.

Test Plan:
- Reset: assert rst_n=0 mid-CMD -> cmd_valid=0, cmd_addr=0 the same cycle; after release, the first write of ch0 goes to addr 0.
- Single channel, CH_NUM=2, FRAME_WORDS=200, BURST_LEN=64, ch_wr_level=64 held, ready=1 -> write cmds len 64,64,64,8 at addr 0,64,128,192; then none until vin vsync.
- Round robin: all slots eligible, CH_NUM=2 -> grant order wr0, rd0, wr1, rd1, wr0 (cmd_ch 0,0,1,1,0; cmd_wr 1,0,1,0,1).
- Stall: cmd_ready low 10 cycles -> cmd_valid stays 1 and addr/len/ch/wr are unchanged; offset advances by len only after the handshake.
- Deferred vsync: ch0 vin edge during WAIT -> bank unchanged until burst_done, then the next ch0 write uses addr 1*BANK_STRIDE+0.
- Dropped frame: vin vsync at wr_off=128 -> next write at the same bank, offset 0, done_bank unchanged. Full frame + vout_vs -> read addr = that bank*BANK_STRIDE; the following writer bank skips it.

Source files
------------

// File: rtl/ddr_nch_frame_arbiter.sv
// Shares one DDR command port among CH_NUM camera-write / display-read channels, each
// owning a ring of BANK_NUM frame buffers rotated by vsync so the reader never sees a torn frame.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | apply pending vsyncs, wait for any eligible slot
// ARB   | pick first eligible slot from the RR pointer, latch command fields
// CMD   | cmd_valid_o high, fields frozen until cmd_ready_i
// WAIT  | one burst outstanding, wait for burst_done_i

module ddr_nch_frame_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int ADDR_W      = 28,
  parameter int LEN_W       = 10,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 76800,
  parameter int BANK_NUM    = 3,
  parameter int BANK_STRIDE = 1 << 20,
  parameter int CH_STRIDE   = 1 << 22,
  localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [CH_NUM-1:0]        ch_en_i,
  input  logic [CH_NUM*LEN_W-1:0]  ch_wr_level_i,
  input  logic [CH_NUM*LEN_W-1:0]  ch_rd_space_i,
  input  logic [CH_NUM-1:0]        ch_vin_vs_i,
  input  logic                     vout_vs_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_wr_o,
  output logic [CH_W-1:0]          cmd_ch_o,
  output logic [ADDR_W-1:0]        cmd_addr_o,
  output logic [LEN_W-1:0]         cmd_len_o,
  input  logic                     burst_done_i
);

  localparam int SLOT_NUM = 2 * CH_NUM;
  localparam int SLOT_W   = $clog2(SLOT_NUM);
  localparam int BANK_W   = $clog2(BANK_NUM);
  localparam int OFF_W    = $clog2(FRAME_WORDS + 1);
  localparam logic [OFF_W-1:0] FRAME_OFF = OFF_W'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_CMD, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   wr_bank_q   [CH_NUM];
  logic [BANK_W-1:0]   wr_bank_d   [CH_NUM];
  logic [BANK_W-1:0]   done_bank_q [CH_NUM];
  logic [BANK_W-1:0]   done_bank_d [CH_NUM];
  logic [BANK_W-1:0]   rd_bank_q   [CH_NUM];
  logic [BANK_W-1:0]   rd_bank_d   [CH_NUM];
  logic [OFF_W-1:0]    wr_off_q    [CH_NUM];
  logic [OFF_W-1:0]    wr_off_d    [CH_NUM];
  logic [OFF_W-1:0]    rd_off_q    [CH_NUM];
  logic [OFF_W-1:0]    rd_off_d    [CH_NUM];
  logic [CH_NUM-1:0]   vin_prev_q, vin_pend_q, vin_pend_d;
  logic                vout_prev_q, vout_pend_q, vout_pend_d;
  logic [SLOT_W-1:0]   rr_q, rr_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [CH_W-1:0]     cmd_ch_q, cmd_ch_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;

  logic [LEN_W-1:0]    wr_len [CH_NUM];
  logic [LEN_W-1:0]    rd_len [CH_NUM];
  logic [SLOT_NUM-1:0] elig;
  logic                grant_ok;
  logic [SLOT_W-1:0]   grant_slot;
  logic [CH_W-1:0]     grant_ch;
  logic                grant_wr;
  logic [CH_NUM-1:0]   vin_apply;
  logic                vout_apply;

  function automatic logic [LEN_W-1:0] burst_len(input logic [OFF_W-1:0] off);
    logic [31:0] rem;
    rem = 32'(FRAME_OFF - off);
    if (rem > 32'(BURST_LEN)) return LEN_W'(BURST_LEN);
    return LEN_W'(rem);
  endfunction

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] cur,
                                                  input logic [BANK_W-1:0] skip);
    int n;
    n = (int'(cur) + 1) % BANK_NUM;
    if (n == int'(skip)) n = (n + 1) % BANK_NUM;
    return BANK_W'(n);
  endfunction

  // Live edges are folded in so a vsync seen while IDLE is applied that very cycle.
  assign vin_apply  = vin_pend_q | (ch_vin_vs_i & ~vin_prev_q);
  assign vout_apply = vout_pend_q | (vout_vs_i & ~vout_prev_q);

  always_comb begin
    elig = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_len[i] = burst_len(wr_off_q[i]);
      rd_len[i] = burst_len(rd_off_q[i]);
      elig[2*i]   = ch_en_i[i] && (wr_off_q[i] < FRAME_OFF) &&
                    (ch_wr_level_i[i*LEN_W +: LEN_W] >= wr_len[i]);
      elig[2*i+1] = ch_en_i[i] && (rd_off_q[i] < FRAME_OFF) &&
                    (ch_rd_space_i[i*LEN_W +: LEN_W] >= rd_len[i]);
    end
  end

  always_comb begin
    grant_ok   = 1'b0;
    grant_slot = '0;
    for (int k = 0; k < SLOT_NUM; k++) begin
      if (!grant_ok && elig[(int'(rr_q) + k) % SLOT_NUM]) begin
        grant_ok   = 1'b1;
        grant_slot = SLOT_W'((int'(rr_q) + k) % SLOT_NUM);
      end
    end
  end

  assign grant_ch = CH_W'(grant_slot >> 1);
  assign grant_wr = ~grant_slot[0];

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    done_bank_d = done_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_off_d    = wr_off_q;
    rd_off_d    = rd_off_q;
    vin_pend_d  = vin_pend_q | (ch_vin_vs_i & ~vin_prev_q);
    vout_pend_d = vout_pend_q | (vout_vs_i & ~vout_prev_q);
    rr_d        = rr_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_ch_d    = cmd_ch_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;

    case (state_q)
      S_IDLE: begin
        vin_pend_d  = '0;
        vout_pend_d = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
          // Reader swaps first so a same-cycle writer rotation skips the bank it now owns.
          if (vout_apply) begin
            rd_bank_d[i] = done_bank_q[i];
            rd_off_d[i]  = '0;
          end
          if (vin_apply[i]) begin
            if (wr_off_q[i] == FRAME_OFF) begin
              done_bank_d[i] = wr_bank_q[i];
              wr_bank_d[i]   = next_bank(wr_bank_q[i], rd_bank_d[i]);
            end
            wr_off_d[i] = '0;
          end
        end
        if (|elig) state_d = S_ARB;
      end
      S_ARB: begin
        if (grant_ok) begin
          cmd_wr_d   = grant_wr;
          cmd_ch_d   = grant_ch;
          cmd_len_d  = grant_wr ? wr_len[grant_ch] : rd_len[grant_ch];
          cmd_addr_d = ADDR_W'(CH_STRIDE) * ADDR_W'(grant_ch) +
                       ADDR_W'(BANK_STRIDE) *
                       ADDR_W'(grant_wr ? wr_bank_q[grant_ch] : rd_bank_q[grant_ch]) +
                       ADDR_W'(grant_wr ? wr_off_q[grant_ch] : rd_off_q[grant_ch]);
          rr_d       = SLOT_W'((int'(grant_slot) + 1) % SLOT_NUM);
          state_d    = S_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (cmd_ready_i) begin
          if (cmd_wr_q) wr_off_d[cmd_ch_q] = wr_off_q[cmd_ch_q] + OFF_W'(cmd_len_q);
          else          rd_off_d[cmd_ch_q] = rd_off_q[cmd_ch_q] + OFF_W'(cmd_len_q);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (burst_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      for (int i = 0; i < CH_NUM; i++) begin
        wr_bank_q[i]   <= '0;
        done_bank_q[i] <= BANK_W'(BANK_NUM - 1);
        rd_bank_q[i]   <= BANK_W'(BANK_NUM - 1);
        wr_off_q[i]    <= '0;
        rd_off_q[i]    <= '0;
      end
      vin_prev_q  <= '0;
      vin_pend_q  <= '0;
      vout_prev_q <= 1'b0;
      vout_pend_q <= 1'b0;
      rr_q        <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_ch_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      done_bank_q <= done_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_off_q    <= wr_off_d;
      rd_off_q    <= rd_off_d;
      vin_prev_q  <= ch_vin_vs_i;
      vin_pend_q  <= vin_pend_d;
      vout_prev_q <= vout_vs_i;
      vout_pend_q <= vout_pend_d;
      rr_q        <= rr_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_ch_q    <= cmd_ch_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign cmd_valid_o = (state_q == S_CMD);
  assign cmd_wr_o    = cmd_wr_q;
  assign cmd_ch_o    = cmd_ch_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_len_o   = cmd_len_q;

endmodule

// File: tb/tb_ddr_nch_frame_arbiter.sv
// Bench for ddr_nch_frame_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of slots, offsets and bank rotation.

module tb_ddr_nch_frame_arbiter;
  localparam int CH = 2;
  localparam int AW = 28;
  localparam int LW = 10;
  localparam int BL = 64;
  localparam int FW = 200;
  localparam int BN = 3;
  localparam int BS = 1 << 20;
  localparam int CS = 1 << 22;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0]    ch_en = '0, vin = '0;
  logic [CH*LW-1:0] wr_level = '0, rd_space = '0;
  logic vout = 1'b0, cmd_ready = 1'b0, burst_done = 1'b0;
  logic cmd_valid, cmd_wr;
  logic [0:0]    cmd_ch;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  always #5 clk = ~clk;

  ddr_nch_frame_arbiter #(
    .CH_NUM(CH), .ADDR_W(AW), .LEN_W(LW), .BURST_LEN(BL), .FRAME_WORDS(FW),
    .BANK_NUM(BN), .BANK_STRIDE(BS), .CH_STRIDE(CS)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ch_en_i(ch_en), .ch_wr_level_i(wr_level),
    .ch_rd_space_i(rd_space), .ch_vin_vs_i(vin), .vout_vs_i(vout),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_wr_o(cmd_wr),
    .cmd_ch_o(cmd_ch), .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
    .burst_done_i(burst_done)
  );

  int errors = 0, checks = 0;

  // reference model state
  int m_wb[CH], m_db[CH], m_rb[CH], m_wo[CH], m_ro[CH], m_rr;
  int pend_vin;
  bit pend_vout, busy;
  int en_mask, lv_wr[CH], lv_rd[CH];
  int ra, rl, rw, rc;

  function automatic int m_len(int off);
    return (FW - off < BL) ? FW - off : BL;
  endfunction

  function automatic bit m_elig(int s);
    int c = s / 2;
    if (((en_mask >> c) & 1) == 0) return 1'b0;
    if (s % 2 == 0) return (m_wo[c] < FW) && (lv_wr[c] >= m_len(m_wo[c]));
    return (m_ro[c] < FW) && (lv_rd[c] >= m_len(m_ro[c]));
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < 2 * CH; k++)
      if (m_elig((m_rr + k) % (2 * CH))) return (m_rr + k) % (2 * CH);
    return -1;
  endfunction

  task automatic m_apply(input int vm, input bit vo);
    if (vo) for (int c = 0; c < CH; c++) begin m_rb[c] = m_db[c]; m_ro[c] = 0; end
    for (int c = 0; c < CH; c++) begin
      if ((vm >> c) & 1) begin
        if (m_wo[c] == FW) begin
          int nb;
          m_db[c] = m_wb[c];
          nb = (m_wb[c] + 1) % BN;
          if (nb == m_rb[c]) nb = (nb + 1) % BN;
          m_wb[c] = nb;
        end
        m_wo[c] = 0;
      end
    end
  endtask

  task automatic drive_levels();
    for (int c = 0; c < CH; c++) begin
      wr_level[c*LW +: LW] = LW'(lv_wr[c]);
      rd_space[c*LW +: LW] = LW'(lv_rd[c]);
    end
    ch_en = CH'(en_mask);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_ready = 1'b0; burst_done = 1'b0; vin = '0; vout = 1'b0;
    en_mask = 0;
    for (int c = 0; c < CH; c++) begin
      lv_wr[c] = 0; lv_rd[c] = 0;
      m_wb[c] = 0; m_db[c] = BN - 1; m_rb[c] = BN - 1; m_wo[c] = 0; m_ro[c] = 0;
    end
    drive_levels();
    m_rr = 0; pend_vin = 0; pend_vout = 1'b0; busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Vsync pulses last one cycle; while a burst is outstanding they are only remembered.
  task automatic set_inputs(input int en, input int w0, input int w1, input int r0,
                            input int r1, input int vm, input bit vo);
    @(negedge clk);
    en_mask = en; lv_wr[0] = w0; lv_wr[1] = w1; lv_rd[0] = r0; lv_rd[1] = r1;
    drive_levels();
    vin = CH'(vm); vout = vo;
    if (busy) begin pend_vin |= vm; pend_vout |= vo; end
    else m_apply(vm, vo);
    @(negedge clk);
    vin = '0; vout = 1'b0;
  endtask

  task automatic pulse_vs(input int vm, input bit vo);
    set_inputs(en_mask, lv_wr[0], lv_wr[1], lv_rd[0], lv_rd[1], vm, vo);
  endtask

  task automatic run_cmd(input int stall, output int a, output int l, output int w, output int c);
    int exp, ec, eo, ea, el;
    bit got, ew, stable;
    logic [AW-1:0] sa; logic [LW-1:0] sl; logic sw; logic [0:0] sc;
    exp = m_pick(); got = 1'b0; a = -1; l = -1; w = -1; c = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cmd_timeout: cmd_valid stayed 0 for 40 cycles, required a command for slot %0d", exp);
      return;
    end
    a = int'(cmd_addr); l = int'(cmd_len); w = int'(cmd_wr); c = int'(cmd_ch);
    if (exp < 0) begin
      errors++;
      $display("FAIL cmd_unexpected: got wr=%0d ch=%0d addr=%0d len=%0d, required no command", w, c, a, l);
    end else begin
      ew = (exp % 2 == 0); ec = exp / 2;
      eo = ew ? m_wo[ec] : m_ro[ec];
      el = m_len(eo);
      ea = ec * CS + (ew ? m_wb[ec] : m_rb[ec]) * BS + eo;
      if (cmd_wr !== ew || cmd_ch !== 1'(ec) || cmd_addr !== AW'(ea) || cmd_len !== LW'(el)) begin
        errors++;
        $display("FAIL cmd_fields: got wr=%0d ch=%0d addr=%0d len=%0d, required wr=%0d ch=%0d addr=%0d len=%0d",
                 w, c, a, l, ew, ec, ea, el);
      end
    end
    sa = cmd_addr; sl = cmd_len; sw = cmd_wr; sc = cmd_ch; stable = 1'b1;
    for (int t = 0; t < stall; t++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_addr !== sa || cmd_len !== sl || cmd_wr !== sw || cmd_ch !== sc)
        stable = 1'b0;
    end
    if (stall > 0) begin
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL cmd_stall_hold: valid=%0d addr=%0d len=%0d, required valid=1 addr=%0d len=%0d held",
                 cmd_valid, cmd_addr, cmd_len, sa, sl);
      end
    end
    cmd_ready = 1'b1;
    @(posedge clk);
    if (exp >= 0) begin
      if (exp % 2 == 0) m_wo[exp/2] += m_len(m_wo[exp/2]);
      else              m_ro[exp/2] += m_len(m_ro[exp/2]);
      m_rr = (exp + 1) % (2 * CH);
    end
    busy = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL cmd_valid_drop: cmd_valid=%0d after handshake, required 0", cmd_valid);
    end
  endtask

  task automatic finish_burst();
    @(negedge clk); burst_done = 1'b1;
    @(negedge clk); burst_done = 1'b0;
    busy = 1'b0;
    m_apply(pend_vin, pend_vout);
    pend_vin = 0; pend_vout = 1'b0;
  endtask

  task automatic expect_idle(input int n, input bit stray_done);
    bit bad = 1'b0;
    checks++;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      burst_done = stray_done && (t == 2);
      if (cmd_valid !== 1'b0) bad = 1'b1;
    end
    burst_done = 1'b0;
    if (bad) begin
      errors++;
      $display("FAIL idle: cmd_valid went 1 during %0d idle cycles, required 0", n);
    end
  endtask

  task automatic wr_burst(input string name, input int vm, input int exp_a, input int exp_l);
    run_cmd(0, ra, rl, rw, rc);
    if (exp_a >= 0) begin
      checks++;
      if (ra != exp_a || rw != 1 || (exp_l >= 0 && rl != exp_l)) begin
        errors++;
        $display("FAIL %s: got wr=%0d addr=%0d len=%0d, required wr=1 addr=%0d len=%0d",
                 name, rw, ra, rl, exp_a, exp_l);
      end
    end
    if (vm != 0) pulse_vs(vm, 1'b0);
    finish_burst();
  endtask

  task automatic test_reset();
    bit got = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_wr !== 1'b0 || cmd_ch !== 1'b0 || cmd_addr !== '0 || cmd_len !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0d wr=%0d ch=%0d addr=%0d len=%0d, required all 0",
               cmd_valid, cmd_wr, cmd_ch, cmd_addr, cmd_len);
    end
    do_reset();
    expect_idle(6, 1'b1);
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      if (cmd_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got || cmd_addr !== '0) begin
      errors++;
      $display("FAIL reset_first_cmd: valid=%0d addr=%0d, required valid=1 addr=0", cmd_valid, cmd_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || cmd_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_cmd: valid=%0d addr=%0d, required valid=0 addr=0", cmd_valid, cmd_addr);
    end
    do_reset();
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    wr_burst("reset_restart", 0, 0, 64);
  endtask

  task automatic test_single_channel();
    int ea[4] = '{0, 64, 128, 192};
    int el[4] = '{64, 64, 64, 8};
    do_reset();
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    for (int b = 0; b < 4; b++) wr_burst("single_burst", 0, ea[b], el[b]);
    expect_idle(20, 1'b1);
    pulse_vs(1, 1'b0);
    wr_burst("single_next_bank", 0, BS, 64);
  endtask

  task automatic test_round_robin();
    int ec[5] = '{0, 0, 1, 1, 0};
    int ew[5] = '{1, 0, 1, 0, 1};
    do_reset();
    set_inputs(3, 64, 64, 64, 64, 0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      run_cmd(0, ra, rl, rw, rc);
      checks++;
      if (rc != ec[b] || rw != ew[b]) begin
        errors++;
        $display("FAIL rr_order: grant %0d got ch=%0d wr=%0d, required ch=%0d wr=%0d", b, rc, rw, ec[b], ew[b]);
      end
      finish_burst();
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    run_cmd(10, ra, rl, rw, rc);
    finish_burst();
    wr_burst("stall_offset", 0, 64, 64);
  endtask

  task automatic test_deferred_vsync();
    do_reset();
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    for (int b = 0; b < 3; b++) wr_burst("deferred_fill", 0, -1, -1);
    run_cmd(0, ra, rl, rw, rc);
    pulse_vs(1, 1'b0);
    expect_idle(5, 1'b0);
    finish_burst();
    wr_burst("deferred_bank1", 0, BS, 64);
  endtask

  task automatic test_dropped_frame();
    do_reset();
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    wr_burst("drop_b0", 0, 0, 64);
    wr_burst("drop_b1", 1, 64, 64);
    wr_burst("drop_restart", 0, 0, 64);
    wr_burst("frame_a", 0, -1, -1);
    wr_burst("frame_a", 0, -1, -1);
    wr_burst("frame_a_end", 1, 192, 8);
    wr_burst("frame_b_start", 0, BS, 64);
    for (int b = 0; b < 3; b++) wr_burst("frame_b", b == 2, -1, -1);
    run_cmd(0, ra, rl, rw, rc);
    checks++;
    if (ra != 0 || rw != 1) begin
      errors++;
      $display("FAIL frame_c_start: got wr=%0d addr=%0d, required wr=1 addr=0", rw, ra);
    end
    set_inputs(1, 64, 0, 64, 0, 0, 1'b1);
    finish_burst();
    run_cmd(0, ra, rl, rw, rc);
    checks++;
    if (ra != BS || rw != 0) begin
      errors++;
      $display("FAIL read_done_bank: got wr=%0d addr=%0d, required wr=0 addr=%0d", rw, ra, BS);
    end
    set_inputs(1, 64, 0, 0, 0, 0, 1'b0);
    finish_burst();
    for (int b = 0; b < 3; b++) wr_burst("frame_c", b == 2, -1, -1);
    wr_burst("writer_skips_reader", 0, 2 * BS, 64);
  endtask

  task automatic rand_inputs();
    int en = 0, vm = 0;
    for (int c = 0; c < CH; c++) begin
      if ($urandom_range(0, 3) != 0) en |= (1 << c);
      if ($urandom_range(0, 3) == 0) vm |= (1 << c);
    end
    set_inputs(en, $urandom_range(48, 80), $urandom_range(48, 80),
               $urandom_range(48, 80), $urandom_range(48, 80), vm, $urandom_range(0, 3) == 0);
  endtask

  task automatic test_random();
    do_reset();
    rand_inputs();
    for (int it = 0; it < 250; it++) begin
      if (m_pick() >= 0) begin
        run_cmd($urandom_range(0, 2), ra, rl, rw, rc);
        rand_inputs();
        finish_burst();
      end else begin
        expect_idle(8, 1'b1);
        rand_inputs();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stall();
    test_deferred_vsync();
    test_dropped_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
